regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port among NUM_REQ requesters (e.g. ALU writeback, load unit, link-register write, debug).
- Each cycle it selects one requester by round-robin and registers its address and data. The registered address and enable drive the 3:8 write-select decoder.
- A requester may lock the port for a multi-cycle burst, bounded by LOCK_MAX.
- Writes aimed at the hardwired zero register are accepted but suppressed.

---
 rtl/regfile_arb_pkg.sv | 16 +
 rtl/rr_priority_pick.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 157 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and default sizing for the register-file write-port arbiter.
package regfile_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF  = 4;
    localparam int ADDR_W_DEF   = 3;
    localparam int DATA_W_DEF   = 64;
    localparam int LOCK_MAX_DEF = 4;
    localparam int ZERO_REG_DEF = 7;
    localparam bit ZERO_EN_DEF  = 1'b1;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first asserted request scanning upward from
// rr_ptr_i, wrapping modulo NUM_REQ.
module rr_priority_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
    output logic [NUM_REQ-1:0]         winner_oh_o,
    output logic [$clog2(NUM_REQ)-1:0] winner_idx_o,
    output logic                       any_valid_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    // NUM_REQ is a power of two, so the natural IDX_W-bit wrap is the modulo.
    always_comb begin
        winner_oh_o  = '0;
        winner_idx_o = '0;
        any_valid_o  = 1'b0;
        cand         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = rr_ptr_i + IDX_W'(k);
            if (!any_valid_o && req_i[cand]) begin
                any_valid_o       = 1'b1;
                winner_idx_o      = cand;
                winner_oh_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ requesters: round-robin pick,
// bounded burst lock, registered write outputs with zero-register suppression.
//
// state  | meaning
// IDLE   | round-robin pick among all requesters starting at rr_ptr
// LOCKED | port held by owner; up to LOCK_MAX further grants, then back to IDLE
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int LOCK_MAX = LOCK_MAX_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter bit ZERO_EN  = ZERO_EN_DEF
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          lock,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          gnt,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic [$clog2(NUM_REQ)-1:0]  owner
);
    localparam int                IDX_W    = $clog2(NUM_REQ);
    localparam int                LCNT_W   = $clog2(LOCK_MAX + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_MAX);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0] pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    logic [NUM_REQ-1:0] gnt_raw;
    logic               accept;
    logic [IDX_W-1:0]   acc_idx;
    logic [ADDR_W-1:0]  addr_sel;
    logic [DATA_W-1:0]  data_sel;
    logic               zero_hit;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [DATA_W-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i        (req),
        .rr_ptr_i     (rr_ptr_q),
        .winner_oh_o  (pick_oh),
        .winner_idx_o (pick_idx),
        .any_valid_o  (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_cnt_d = lock_cnt_q;
        gnt_raw    = '0;
        accept     = 1'b0;
        acc_idx    = owner_q;
        case (state_q)
            IDLE: begin
                if (enable && pick_any) begin
                    gnt_raw = pick_oh;
                    accept  = 1'b1;
                    acc_idx = pick_idx;
                    if (lock[pick_idx]) begin
                        state_d    = LOCKED;
                        lock_cnt_d = LCNT_W'(1);
                    end else begin
                        rr_ptr_d = pick_idx + IDX_W'(1);
                    end
                end
            end
            LOCKED: begin
                // enable low pauses the burst without consuming or ending it
                if (enable) begin
                    if (req[owner_q] && lock[owner_q]) begin
                        gnt_raw[owner_q] = 1'b1;
                        accept           = 1'b1;
                        if (lock_cnt_q < LCNT_MAX) begin
                            lock_cnt_d = lock_cnt_q + LCNT_W'(1);
                        end else begin
                            state_d    = IDLE;
                            rr_ptr_d   = owner_q + IDX_W'(1);
                            lock_cnt_d = '0;
                        end
                    end else begin
                        state_d    = IDLE;
                        rr_ptr_d   = owner_q + IDX_W'(1);
                        lock_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    assign addr_sel = addr_arr[acc_idx];
    assign data_sel = data_arr[acc_idx];
    assign zero_hit = ZERO_EN && (addr_sel == ADDR_W'(ZERO_REG));

    always_comb begin
        wr_en_d   = accept && !zero_hit;
        wr_addr_d = accept ? addr_sel : wr_addr_q;
        wr_data_d = accept ? data_sel : wr_data_q;
        owner_d   = accept ? acc_idx  : owner_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            lock_cnt_q <= '0;
            owner_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_cnt_q <= lock_cnt_d;
            owner_q    <= owner_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Grants are masked combinationally so nothing is offered while in reset.
    assign gnt     = gnt_raw & {NUM_REQ{reset_n}};
    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed vectors push expected writes,
// a negedge monitor pops and compares whenever wr_en is presented.
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int NR = 4;
    localparam int AW = 3;
    localparam int DW = 64;

    logic          clk;
    logic          reset_n;
    logic          enable;
    logic [NR-1:0] req;
    logic [NR-1:0] lock;
    logic [NR-1:0] gnt;
    logic [AW-1:0] a [NR];
    logic [DW-1:0] d [NR];
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    owner;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    own;
    } wr_t;

    wr_t exp_q [$];
    wr_t mon_e;
    wr_t push_e;
    int  checks   = 0;
    int  failures = 0;
    logic [NR-1:0] lock_seq [8];

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = a[i];
            req_data[i*DW +: DW] = d[i];
        end
    end

    regfile_write_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .req      (req),
        .lock     (lock),
        .req_addr (req_addr),
        .req_data (req_data),
        .gnt      (gnt),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .owner    (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Check the combinational grant, push the write it implies, then cross one rising edge.
    task automatic step(input logic [NR-1:0] exp_gnt, input string name);
        int idx;
        idx = -1;
        #1;
        chk({name, " gnt"}, 64'(gnt), 64'(exp_gnt));
        for (int i = 0; i < NR; i++) if (exp_gnt[i]) idx = i;
        if (idx >= 0 && a[idx] != 3'd7) begin
            push_e.addr = a[idx];
            push_e.data = d[idx];
            push_e.own  = 2'(idx);
            exp_q.push_back(push_e);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset_n && wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write: unexpected wr_en addr=%0d data=%0h owner=%0d, no write expected",
                         wr_addr, wr_data, owner);
            end else begin
                mon_e = exp_q.pop_front();
                if ({wr_addr, wr_data, owner} !== mon_e) begin
                    failures++;
                    $display("FAIL write: got addr=%0d data=%0h owner=%0d expected addr=%0d data=%0h owner=%0d",
                             wr_addr, wr_data, owner, mon_e.addr, mon_e.data, mon_e.own);
                end
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        enable  = 1'b1;
        req     = 4'b1111;
        lock    = 4'b0000;
        for (int i = 0; i < NR; i++) begin
            a[i] = AW'(i + 1);
            d[i] = 64'h0123_4567_89AB_CDE0 + 64'(i);
        end
        lock_seq[0] = 4'b0001; lock_seq[1] = 4'b0001; lock_seq[2] = 4'b0001;
        lock_seq[3] = 4'b0001; lock_seq[4] = 4'b0001; lock_seq[5] = 4'b1000;
        lock_seq[6] = 4'b0001; lock_seq[7] = 4'b0001;

        // reset held with every requester asserted
        #1 reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset gnt", 64'(gnt), 64'h0);
        chk("reset wr_en", 64'(wr_en), 64'h0);
        chk("reset owner", 64'(owner), 64'h0);
        chk("reset wr_addr", 64'(wr_addr), 64'h0);
        chk("reset wr_data", wr_data, 64'h0);
        reset_n = 1'b1;

        // back-to-back round robin 0,1,2,3
        step(4'b0001, "rr0");
        step(4'b0010, "rr1");
        step(4'b0100, "rr2");
        step(4'b1000, "rr3");
        req = 4'b0000;
        step(4'b0000, "rr idle");

        // single requester, same-cycle grant, 1-cycle write latency
        req  = 4'b0100;
        a[2] = 3'd5;
        d[2] = 64'hDEAD_BEEF;
        step(4'b0100, "single");
        chk("single owner", 64'(owner), 64'd2);
        chk("single wr_en", 64'(wr_en), 64'd1);
        chk("single wr_addr", 64'(wr_addr), 64'd5);
        chk("single wr_data", wr_data, 64'hDEAD_BEEF);
        req = 4'b0000;
        step(4'b0000, "single idle");

        // zero register accepted but suppressed, neighbour register written
        req  = 4'b0010;
        a[1] = 3'd7;
        step(4'b0010, "zero");
        chk("zero wr_en", 64'(wr_en), 64'd0);
        chk("zero owner", 64'(owner), 64'd1);
        a[1] = 3'd6;
        step(4'b0010, "nonzero");
        chk("nonzero wr_en", 64'(wr_en), 64'd1);
        chk("nonzero wr_addr", 64'(wr_addr), 64'd6);
        req = 4'b0000;
        step(4'b0000, "zero idle");

        // burst lock of requester 0 against requester 3: 5 grants, then 3, then 0 again
        do_reset();
        req  = 4'b1001;
        lock = 4'b0001;
        for (int i = 0; i < 8; i++) step(lock_seq[i], "lock seq");
        req  = 4'b0000;
        lock = 4'b0000;
        step(4'b0000, "lock exit");

        // pause mid-burst after the second grant
        req  = 4'b1010;
        lock = 4'b0010;
        step(4'b0010, "pause lock");
        step(4'b0010, "pause g2");
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(4'b0000, "paused");
            chk("paused wr_en", 64'(wr_en), 64'd0);
        end
        enable = 1'b1;
        for (int i = 0; i < 3; i++) step(4'b0010, "resume");
        step(4'b1000, "after burst");
        req  = 4'b0000;
        lock = 4'b0000;
        step(4'b0000, "pause idle");

        // asynchronous reset pulse in the middle of a burst by requester 2
        do_reset();
        req  = 4'b0100;
        lock = 4'b0100;
        a[2] = 3'd4;
        step(4'b0100, "burst lock");
        step(4'b0100, "burst g2");
        #2 reset_n = 1'b0;
        #1;
        chk("mid-reset gnt", 64'(gnt), 64'h0);
        chk("mid-reset wr_en", 64'(wr_en), 64'h0);
        chk("mid-reset owner", 64'(owner), 64'h0);
        chk("mid-reset wr_addr", 64'(wr_addr), 64'h0);
        req  = 4'b0000;
        lock = 4'b0000;
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post-release wr_en", 64'(wr_en), 64'h0);
        req = 4'b1111;
        step(4'b0001, "post-reset idle");
        req = 4'b0000;
        step(4'b0000, "final idle");

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
